// File: rtl/wdt_pkg.sv
// Shared definitions for the software watchdog timer.
//   wdt_state_e    : watchdog state encoding (also the WdtState readback value)
//   CNT_W_DEF      : default width of the timeout/count field, in 125 ms ticks
//   TICK_PERIOD_MS : period of the Strobe125msec tick
package wdt_pkg;

  typedef enum logic [1:0] {
    WDT_IDLE = 2'd0,
    WDT_RUN  = 2'd1,
    WDT_HOLD = 2'd2,
    WDT_LOCK = 2'd3
  } wdt_state_e;

  localparam int CNT_W_DEF      = 8;
  localparam int TICK_PERIOD_MS = 125;

endpackage

// File: rtl/wdt_tick_counter.sv
// Loadable down-counter used for both the watchdog count and the reset hold
// count.  Load has priority over decrement; decrement saturates at zero.
// Ports:
//   LpcClock, ResetN : clock, async active-low reset (count resets to 0)
//   load, load_val   : synchronous load
//   dec              : decrement by one (ignored when count is already 0)
//   count            : registered count
//   count_nxt        : value count takes at the next edge
//   dec_done         : this decrement takes the count from 1 to 0
module wdt_tick_counter #(
  parameter int W = 8
) (
  input  logic         LpcClock,
  input  logic         ResetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         dec_done
);

  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (dec && (count != '0)) begin
      count_nxt = count - W'(1);
    end
  end

  assign dec_done = dec && !load && (count == W'(1));

  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/wdt_timer.sv
// Software watchdog timer, LpcClock domain.  Counts down a programmable
// timeout in 125 ms ticks, flags a pre-warning near the end, then requests a
// board reset for HOLD_TICKS ticks and locks until software drops the enable.
//
//   state | meaning
//   IDLE  | disarmed, count held at 0
//   RUN   | armed, counting down on each strobe, kick reloads
//   HOLD  | expired, reset request asserted, cannot be aborted
//   LOCK  | request finished, waits for WdtEnable=0 before re-arming
//
// Ports:
//   LpcClock, ResetN  : clock, async active-low reset
//   Strobe125msec     : one-cycle 125 ms tick
//   WdtEnable         : arm level
//   WdtKick           : service pulse, reloads the count in RUN
//   WdtTimeout        : reload value in ticks (0 keeps the block idle)
//   WdtClearStatus    : clears the sticky WdtExpired flag
//   WdtCount          : remaining ticks
//   WdtState          : current state encoding
//   WdtPreWarn        : count is nonzero and within PREWARN_TICKS in RUN
//   WdtResetReq       : reset request to the power/reset sequencer
//   WdtExpired        : sticky expiry flag
module wdt_timer
  import wdt_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int PREWARN_TICKS = 8,
  parameter int HOLD_TICKS    = 4
) (
  input  logic             LpcClock,
  input  logic             ResetN,
  input  logic             Strobe125msec,
  input  logic             WdtEnable,
  input  logic             WdtKick,
  input  logic [CNT_W-1:0] WdtTimeout,
  input  logic             WdtClearStatus,
  output logic [CNT_W-1:0] WdtCount,
  output logic [1:0]       WdtState,
  output logic             WdtPreWarn,
  output logic             WdtResetReq,
  output logic             WdtExpired
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  wdt_state_e state_q, state_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_expire;

  logic              hold_load;
  logic              hold_dec;
  logic              hold_done;
  logic [HOLD_W-1:0] hold_unused_cnt;
  logic [HOLD_W-1:0] hold_unused_nxt;

  logic expire_set;
  logic prewarn_q;
  logic reset_req_q;
  logic expired_q;

  wdt_tick_counter #(.W(CNT_W)) u_main_cnt (
    .LpcClock  (LpcClock),
    .ResetN    (ResetN),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .dec       (cnt_dec),
    .count     (cnt_q),
    .count_nxt (cnt_nxt),
    .dec_done  (cnt_expire)
  );

  wdt_tick_counter #(.W(HOLD_W)) u_hold_cnt (
    .LpcClock  (LpcClock),
    .ResetN    (ResetN),
    .load      (hold_load),
    .load_val  (HOLD_W'(HOLD_TICKS)),
    .dec       (hold_dec),
    .count     (hold_unused_cnt),
    .count_nxt (hold_unused_nxt),
    .dec_done  (hold_done)
  );

  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= WDT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    hold_load    = 1'b0;
    hold_dec     = 1'b0;
    expire_set   = 1'b0;

    unique case (state_q)
      WDT_IDLE: begin
        // Load 0 when not arming so IDLE always reads back a zero count.
        cnt_load = 1'b1;
        if (WdtEnable && (WdtTimeout != '0)) begin
          cnt_load_val = WdtTimeout;
          state_d      = WDT_RUN;
        end
      end

      WDT_RUN: begin
        if (!WdtEnable) begin
          cnt_load = 1'b1;
          state_d  = WDT_IDLE;
        end else if (WdtKick) begin
          // Kick beats a coincident strobe: reload only, no decrement.
          cnt_load     = 1'b1;
          cnt_load_val = WdtTimeout;
        end else if (Strobe125msec) begin
          cnt_dec = 1'b1;
          if (cnt_expire) begin
            hold_load  = 1'b1;
            expire_set = 1'b1;
            state_d    = WDT_HOLD;
          end
        end
      end

      WDT_HOLD: begin
        // Enable and kick are deliberately ignored so the request runs its
        // full length once issued.
        hold_dec = Strobe125msec;
        if (hold_done) begin
          state_d = WDT_LOCK;
        end
      end

      WDT_LOCK: begin
        if (!WdtEnable) begin
          state_d = WDT_IDLE;
        end
      end

      default: state_d = WDT_IDLE;
    endcase
  end

  // Status flags are registered from next-state values so they line up with
  // the count and state they describe.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      prewarn_q   <= 1'b0;
      reset_req_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      prewarn_q   <= (state_d == WDT_RUN) && (cnt_nxt != '0) &&
                     (cnt_nxt <= CNT_W'(PREWARN_TICKS));
      reset_req_q <= (state_d == WDT_HOLD);
      if (expire_set) begin
        expired_q <= 1'b1;
      end else if (WdtClearStatus) begin
        expired_q <= 1'b0;
      end
    end
  end

  assign WdtCount    = cnt_q;
  assign WdtState    = state_q;
  assign WdtPreWarn  = prewarn_q;
  assign WdtResetReq = reset_req_q;
  assign WdtExpired  = expired_q;

endmodule

// File: doc/wdt_timer.md
Name: wdt_timer

Overview:
- Software watchdog timer in the LpcClock domain.
- Consumes the single-LpcClock-cycle 125 ms strobe produced by the strobe generator stage.
- Counts down a programmable timeout, raises a pre-warning, then requests a board reset for a fixed hold time.
- LPC register logic drives enable/kick/timeout/clear and reads back count, state and sticky status.

Parameters:
- CNT_W, 8, width of timeout/count in 125 ms ticks (max 31.875 s).
- PREWARN_TICKS, 8, pre-warning asserted when remaining count <= this value (1 s).
- HOLD_TICKS, 4, reset-request hold length in ticks (500 ms).

Ports:
- LpcClock  in  1  33 MHz LPC clock, sole clock.
- ResetN  in  1  asynchronous active-low reset.
- Strobe125msec  in  1  one-cycle tick every 125 ms.
- WdtEnable  in  1  level; watchdog armed while high.
- WdtKick  in  1  one-cycle service pulse.
- WdtTimeout  in  CNT_W  reload value in ticks.
- WdtClearStatus  in  1  one-cycle pulse; clears WdtExpired.
- WdtCount  out  CNT_W  remaining ticks.
- WdtState  out  2  0=IDLE, 1=RUN, 2=HOLD, 3=LOCK.
- WdtPreWarn  out  1  pre-expiry warning.
- WdtResetReq  out  1  reset request to power/reset sequencer.
- WdtExpired  out  1  sticky expiry flag.

Behaviour:
- Reset values: all outputs 0, WdtState=IDLE. The hold counter resets to 0.
- Reset is asynchronous; assertion mid-operation drops WdtResetReq immediately.
- All outputs are registered. A decision taken on an input in cycle N is visible in cycle N+1.

IDLE:
- WdtCount=0.
- Moves to RUN when WdtEnable=1 and WdtTimeout!=0, loading WdtCount=WdtTimeout.
- WdtTimeout=0 keeps the block in IDLE regardless of enable.

RUN:
- WdtEnable=0 → IDLE and WdtCount=0 next cycle. Highest priority.
- Else WdtKick=1 → WdtCount=WdtTimeout. A kick wins over a strobe in the same cycle, so no decrement occurs.
- Else Strobe125msec=1 with WdtCount>1 → decrement by 1.
- Else Strobe125msec=1 with WdtCount==1 → the following all happen:
  - WdtCount=0.
  - state HOLD.
  - WdtResetReq=1.
  - WdtExpired=1.
  - hold counter=HOLD_TICKS.
- WdtTimeout changes take effect only at the next load or kick.
- WdtTimeout becoming 0 while in RUN has no effect on the count in progress.

HOLD:
- WdtResetReq=1.
- Kick is ignored. WdtEnable is ignored, so the request cannot be aborted.
- Each strobe decrements the hold counter.
- A strobe with hold==1 → WdtResetReq=0 and state LOCK.

LOCK:
- Stays in LOCK until WdtEnable=0, then goes to IDLE.
- This prevents a re-arm loop without software intervention.

WdtPreWarn:
- Equals (state==RUN && WdtCount!=0 && WdtCount<=PREWARN_TICKS), registered.
- If WdtTimeout<=PREWARN_TICKS, pre-warn asserts right after arming.

WdtExpired:
- Set on expiry.
- Cleared by WdtClearStatus.
- Set wins if both occur in the same cycle.
- Only reset or clear lowers it.

Arithmetic and strobes:
- No wrap-around: the count never decrements below 0.
- All counters are unsigned, CNT_W bits. The hold counter uses clog2(HOLD_TICKS+1) bits.
- Strobe125msec is assumed a clean one-cycle pulse. Back-to-back strobes are each counted.

Decomposition:
- Shared package (wdt_pkg) holds:
  - state encoding constants WDT_IDLE/RUN/HOLD/LOCK.
  - CNT_W default.
  - tick period constant (125 ms).
- One natural sub-module: wdt_tick_counter, a loadable down-counter with load/dec/zero-detect, instantiated for the main count and the hold count.
- The FSM stays in the top.

Test Plan:
- Arm, no kick: WdtTimeout=10, WdtEnable=1.
  - WdtCount=10 after 1 cycle.
  - WdtPreWarn rises after the 2nd strobe (count=8).
  - After the 10th strobe: WdtResetReq=1, WdtExpired=1, state=HOLD.
  - After 4 more strobes: WdtResetReq=0, state=LOCK.
  - WdtEnable=0 → state=IDLE.
- Kick/strobe collision: count=3, WdtKick and Strobe125msec in the same cycle with WdtTimeout=20 → WdtCount=20 (not 2 or 19).
  - WdtPreWarn deasserts next cycle.
- Disable in RUN vs HOLD:
  - In RUN, count=5, WdtEnable=0 → IDLE, WdtCount=0, no expiry.
  - In HOLD, WdtEnable=0 → WdtResetReq stays 1 for the full 4 ticks, then state goes directly to IDLE via LOCK.
- Zero timeout: WdtTimeout=0, WdtEnable=1 for 20 strobes → state stays IDLE, all outputs 0.
  - Change WdtTimeout to 2 → RUN with count=2.
- Sticky status: WdtClearStatus in the same cycle as the expiring strobe → WdtExpired=1.
  - A later WdtClearStatus → 0.
- Async reset mid-HOLD: ResetN low between clock edges → WdtResetReq=0 immediately (before the next LpcClock edge), state=IDLE, WdtExpired=0.
